// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 decryption issue controller.
package aes_pkg;

  localparam int unsigned AES_DECR_LATENCY = 11;
  localparam int unsigned INFLIGHT_W = $clog2(AES_DECR_LATENCY + 2);

  typedef logic [127:0] aes_block_t;

  typedef enum logic [0:0] {
    StRun,
    StDrain
  } sched_state_e;

  function automatic logic [INFLIGHT_W-1:0] popcount_vld(input logic [AES_DECR_LATENCY:0] v);
    return INFLIGHT_W'($countones(v));
  endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// Synchronous result FIFO with occupancy count; head is read combinationally.
module aes_out_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 132,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             full, push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full    = (cnt_q == CntW'(Depth));
    valid_o = (cnt_q != '0);
    pop_ok  = pop_i && valid_o;
    push_ok = push_i && (!full || pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Upstream credit accounting must make a write into a full FIFO impossible.
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_ok));

endmodule

// File: rtl/aes_decr_sched.sv
// Issue controller for the non-stallable 11-stage AES-128 decryption core:
// credit-based admission, in-flight tracking and drain-before-rekey.
module aes_decr_sched
  import aes_pkg::*;
#(
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned TagW      = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [127:0]    in_data_i,
  input  logic [127:0]    in_key_i,
  input  logic [TagW-1:0] in_tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [127:0]    out_data_o,
  output logic [TagW-1:0] out_tag_o,
  output logic [127:0]    core_data_o,
  output logic [127:0]    core_key_o,
  input  logic [127:0]    core_result_i,
  output logic            busy_o
);

  localparam int unsigned Lat  = AES_DECR_LATENCY;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned SumW = ((CntW > INFLIGHT_W) ? CntW : INFLIGHT_W) + 1;

  sched_state_e              state_q, state_d;
  aes_block_t                key_q, core_data_q, core_key_q;
  logic                      key_vld_q;
  logic                      run_en_q;
  logic [Lat:0]              vld_sr_q;
  logic [Lat:0][TagW-1:0]    tag_sr_q;

  logic [INFLIGHT_W-1:0]     inflight;
  logic [CntW-1:0]           fifo_cnt;
  logic                      key_diff, mismatch, drain_done, credit_ok;
  logic                      in_ready, accept;
  logic [TagW-1:0]           tag_in;
  logic [TagW+127:0]         fifo_rdata;

  always_comb begin
    inflight   = popcount_vld(vld_sr_q);
    key_diff   = in_valid_i && (in_key_i != key_q);
    mismatch   = key_diff && key_vld_q && (inflight != '0);
    // Nothing is accepted while draining, so only the oldest slot can retire.
    drain_done = (inflight == INFLIGHT_W'(vld_sr_q[Lat]));
    credit_ok  = (SumW'(fifo_cnt) + SumW'(inflight)) < SumW'(FifoDepth);
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mismatch) begin
          state_d = StDrain;
        end else begin
          in_ready = run_en_q && credit_ok;
        end
      end
      StDrain: begin
        if (drain_done || !key_diff) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign accept = in_valid_i && in_ready;
  assign tag_in = accept ? in_tag_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      run_en_q    <= 1'b0;
      key_q       <= '0;
      key_vld_q   <= 1'b0;
      core_data_q <= '0;
      core_key_q  <= '0;
      vld_sr_q    <= '0;
      tag_sr_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_en_q <= 1'b1;
      vld_sr_q <= {vld_sr_q[Lat-1:0], accept};
      tag_sr_q <= {tag_sr_q[Lat-1:0], tag_in};
      if (accept) begin
        key_q       <= in_key_i;
        key_vld_q   <= 1'b1;
        core_data_q <= in_data_i;
        core_key_q  <= in_key_i;
      end
    end
  end

  aes_out_fifo #(
    .Depth (FifoDepth),
    .Width (TagW + 128)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (vld_sr_q[Lat]),
    .wdata_i ({tag_sr_q[Lat], core_result_i}),
    .pop_i   (out_ready_i),
    .valid_o (out_valid_o),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

  assign in_ready_o  = in_ready;
  assign out_data_o  = fifo_rdata[127:0];
  assign out_tag_o   = fifo_rdata[TagW+127:128];
  assign core_data_o = core_data_q;
  assign core_key_o  = core_key_q;
  assign busy_o      = (inflight != '0) || out_valid_o;

endmodule
